// File: rtl/key_inject_arbiter.sv
// key_inject_arbiter: shares the processor's instruction-injection slot between
// three active-low pushbuttons (KEY3/KEY2/KEY1) and a periodic game tick.
// Each button is synchronized, debounced and turned into a one-shot press event.
// Pending events are granted by fixed priority (tick > KEY3 > KEY2 > KEY1).
// Each grant is presented on a valid/ready handshake.
// Optional feature macro: KEY_INJECT_AUTOREPEAT_EN. When defined, a held button
// re-fires every REPEAT_CYCLES cycles.
module key_inject_arbiter #(
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          TICK_PERIOD     = 1000,
  parameter logic [31:0] LEFT_INSN       = 32'h2843FFE0,
  parameter logic [31:0] RIGHT_INSN      = 32'h28420020,
  parameter logic [31:0] FIRE_INSN       = 32'h0C000010,
  parameter logic [31:0] TICK_INSN       = 32'h0C000020,
  parameter int          REPEAT_CYCLES   = 256
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        KEY3,
  input  logic        KEY2,
  input  logic        KEY1,
  input  logic        inject_ready,
  output logic        inject_valid,
  output logic [31:0] insn_inject,
  output logic [3:0]  inject_src,
  output logic        event_dropped
);

  localparam int DB_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int TK_W = ($clog2(TICK_PERIOD) < 1) ? 1 : $clog2(TICK_PERIOD);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);
  localparam logic [TK_W-1:0] TK_MAX = TK_W'(TICK_PERIOD - 1);
  localparam logic [TK_W-1:0] TK_ONE = TK_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Button bit order everywhere: [2]=KEY3, [1]=KEY2, [0]=KEY1 (raw level, 1 = released)
  logic [2:0] key_raw;
  assign key_raw = {KEY3, KEY2, KEY1};

  logic [2:0]      sync1_q, sync1_d;
  logic [2:0]      sync2_q, sync2_d;
  logic [2:0]      deb_q, deb_d;
  logic [2:0]      deb_prev_q, deb_prev_d;
  logic [2:0]      press_q, press_d;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];
  logic [TK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic            tick_evt;
  logic [3:0]      pend_q, pend_d;
  logic            dropped_q, dropped_d;
  logic [3:0]      events;
  logic [3:0]      grant;
  logic [31:0]     grant_insn;
  logic [2:0]      rep_fire;

  state_t          state_q;
  logic            valid_q;
  logic [31:0]     insn_q;
  logic [3:0]      src_q;

`ifdef KEY_INJECT_AUTOREPEAT_EN
  localparam int RP_W = ($clog2(REPEAT_CYCLES) < 1) ? 1 : $clog2(REPEAT_CYCLES);
  localparam logic [RP_W-1:0] RP_MAX = RP_W'(REPEAT_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_ONE = RP_W'(1);

  logic [RP_W-1:0] rep_cnt_q [3];
  logic [RP_W-1:0] rep_cnt_d [3];

  // Repeat counters run only once the press event has been issued and clear on release
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < 3; i++) begin
      rep_cnt_d[i] = '0;
      if (!deb_q[i] && !deb_prev_q[i]) begin
        if (rep_cnt_q[i] == RP_MAX) begin
          rep_fire[i]  = 1'b1;
          rep_cnt_d[i] = '0;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + RP_ONE;
        end
      end
    end
  end

  // Repeat counter registers
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) rep_cnt_q[i] <= '0;
      else       rep_cnt_q[i] <= rep_cnt_d[i];
    end
  end
`else
  logic repeat_param_unused;
  assign repeat_param_unused = ^REPEAT_CYCLES;
  assign rep_fire = '0;
`endif

  // Synchronize, debounce and edge-detect each button
  always_comb begin
    sync1_d    = key_raw;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      deb_d[i]    = deb_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          deb_d[i]    = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
        end
      end
    end
    press_d = (deb_prev_q & ~deb_q) | rep_fire;
  end

  // Free-running tick counter; the event fires on the wrap cycle
  always_comb begin
    tick_evt   = (tick_cnt_q == TK_MAX);
    tick_cnt_d = tick_evt ? '0 : (tick_cnt_q + TK_ONE);
  end

  // Fixed-priority grant, only offered while the slot is idle
  always_comb begin
    grant      = '0;
    grant_insn = '0;
    if (state_q == IDLE) begin
      if (pend_q[3]) begin
        grant      = 4'b1000;
        grant_insn = TICK_INSN;
      end else if (pend_q[2]) begin
        grant      = 4'b0100;
        grant_insn = LEFT_INSN;
      end else if (pend_q[1]) begin
        grant      = 4'b0010;
        grant_insn = RIGHT_INSN;
      end else if (pend_q[0]) begin
        grant      = 4'b0001;
        grant_insn = FIRE_INSN;
      end
    end
  end

  // Pending bits set on events, cleared by grant; a collision with a held bit is a drop
  always_comb begin
    events    = {tick_evt, press_q};
    pend_d    = (pend_q & ~grant) | events;
    dropped_d = dropped_q | (|(events & pend_q & ~grant));
  end

  // Input conditioning, tick and pending state registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1_q    <= 3'b111;
      sync2_q    <= 3'b111;
      deb_q      <= 3'b111;
      deb_prev_q <= 3'b111;
      press_q    <= '0;
      tick_cnt_q <= '0;
      pend_q     <= '0;
      dropped_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      press_q    <= press_d;
      tick_cnt_q <= tick_cnt_d;
      pend_q     <= pend_d;
      dropped_q  <= dropped_d;
    end
  end

  // Debounce counters
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) db_cnt_q[i] <= '0;
      else       db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Two-state handshake FSM with registered outputs held stable while busy
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      insn_q  <= '0;
      src_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            state_q <= BUSY;
            valid_q <= 1'b1;
            insn_q  <= grant_insn;
            src_q   <= grant;
          end
        end
        BUSY: begin
          if (valid_q && inject_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            insn_q  <= '0;
            src_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          insn_q  <= '0;
          src_q   <= '0;
        end
      endcase
    end
  end

  assign inject_valid  = valid_q;
  assign insn_inject   = insn_q;
  assign inject_src    = src_q;
  assign event_dropped = dropped_q;

endmodule
